// File: rtl/median_fifo_packer.sv
`default_nettype none
// ============================================================================
// Module   : median_fifo_packer
// Brief    : Packs 16-bit audio samples LSB-first into words for the median
//            prefetch FIFO. A flush zero-pads any partial word.
// Revision : 1.0 - initial release
// ============================================================================
module median_fifo_packer #(
    parameter int SAMPLE_WIDTH     = 16,
    parameter int SAMPLES_PER_WORD = 4,
    parameter int CNT_WIDTH        = 32,
    localparam int WORD_WIDTH      = SAMPLE_WIDTH * SAMPLES_PER_WORD
) (
    input  logic                    wr_clk,
    input  logic                    wr_rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SAMPLE_WIDTH-1:0] s_data,
    input  logic                    flush,
    output logic                    flush_done,
    output logic                    wr_en,
    input  logic                    wr_vld,
    output logic [WORD_WIDTH-1:0]   wr_data,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    word_cnt
);

    localparam int                  c_lane_w    = $clog2(SAMPLES_PER_WORD);
    localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(SAMPLES_PER_WORD - 1);
    localparam logic [c_lane_w-1:0] c_lane_one  = c_lane_w'(1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_FLUSH_LOAD  = 2'd1,
        ST_FLUSH_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic [WORD_WIDTH-1:0] r_acc;
    logic [WORD_WIDTH-1:0] r_out;
    logic [c_lane_w-1:0]   r_lane;
    logic                  r_pend;
    logic                  r_flush_done;
    logic [CNT_WIDTH-1:0]  r_word_cnt;

    logic                  w_in_run;
    logic                  w_last;
    logic                  w_xfer;
    logic                  w_slot_free;
    logic [c_lane_w-1:0]   w_lane_inc;
    logic [c_lane_w-1:0]   w_lane_after;
    logic [WORD_WIDTH-1:0] w_acc_ins;

    assign w_in_run    = (r_state == ST_RUN);
    assign w_last      = (r_lane == c_last_lane);
    assign wr_en       = r_pend & wr_vld & ~wr_rst;
    // The last lane may only be filled when out_reg is free or drains this cycle.
    assign s_ready     = ~wr_rst & w_in_run & (~w_last | ~r_pend | wr_en);
    assign w_xfer      = s_valid & s_ready;
    assign w_slot_free = ~r_pend | wr_en;
    assign w_lane_inc  = r_lane + c_lane_one;

    // Lane position once this cycle's transfer (if any) has been applied.
    assign w_lane_after = !w_xfer ? r_lane :
                          (w_last ? '0 : w_lane_inc);

    always_comb begin
        w_acc_ins = r_acc;
        for (int i = 0; i < SAMPLES_PER_WORD; i++) begin
            if (r_lane == c_lane_w'(i)) begin
                w_acc_ins[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = s_data;
            end
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_state      <= ST_RUN;
            r_acc        <= '0;
            r_out        <= '0;
            r_lane       <= '0;
            r_pend       <= 1'b0;
            r_flush_done <= 1'b0;
            r_word_cnt   <= '0;
        end else begin
            r_flush_done <= 1'b0;

            // Later assignments in the state case override this clear on reload.
            if (wr_en) begin
                r_pend     <= 1'b0;
                r_word_cnt <= r_word_cnt + c_cnt_one;
            end

            case (r_state)
                ST_RUN: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_out  <= w_acc_ins;
                            r_pend <= 1'b1;
                            r_lane <= '0;
                            r_acc  <= '0;
                        end else begin
                            r_acc  <= w_acc_ins;
                            r_lane <= w_lane_inc;
                        end
                    end
                    if (flush) begin
                        if (w_lane_after != '0) begin
                            r_state <= ST_FLUSH_LOAD;
                        end else begin
                            r_state <= ST_FLUSH_DRAIN;
                        end
                    end
                end

                ST_FLUSH_LOAD: begin
                    // Unfilled lanes of acc are already zero, giving the padding.
                    if (w_slot_free) begin
                        r_out   <= r_acc;
                        r_pend  <= 1'b1;
                        r_lane  <= '0;
                        r_acc   <= '0;
                        r_state <= ST_FLUSH_DRAIN;
                    end
                end

                ST_FLUSH_DRAIN: begin
                    if (w_slot_free) begin
                        r_flush_done <= 1'b1;
                        r_state      <= ST_RUN;
                    end
                end

                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign wr_data    = r_out;
    assign flush_done = r_flush_done;
    assign word_cnt   = r_word_cnt;
    assign busy       = (r_lane != '0) | r_pend | ~w_in_run;

endmodule
`default_nettype wire
